// File: rtl/clk_tick_gen.sv
// clk_tick_gen: NUM_CH independent programmable tick dividers.
// Each channel emits a registered one-cycle tick every div+1 enabled cycles.
module clk_tick_gen #(
    parameter int                   NUM_CH    = 4,
    parameter int                   CNT_WIDTH = 8,
    parameter logic [CNT_WIDTH-1:0] RESET_DIV = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [NUM_CH-1:0]             restart,
    input  logic [NUM_CH-1:0]             load,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   div_in,
    output logic [NUM_CH-1:0]             tick,
    output logic                          any_tick
);

    logic [NUM_CH-1:0][CNT_WIDTH-1:0] div_reg;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] next_div;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [NUM_CH-1:0]                tick_d;

    // Per-channel next state: restart beats count, count beats hold.
    // A load landing on a reload edge is used for that reload.
    always_comb begin
        next_div = div_reg;
        cnt_d    = cnt;
        tick_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
                next_div[i] = div_in[i*CNT_WIDTH +: CNT_WIDTH];
            end
            if (restart[i]) begin
                cnt_d[i] = next_div[i];
            end else if (enable[i]) begin
                if (cnt[i] == '0) begin
                    tick_d[i] = 1'b1;
                    cnt_d[i]  = next_div[i];
                end else begin
                    cnt_d[i] = cnt[i] - 1'b1;
                end
            end
        end
    end

    // State and output registers; reset discards progress and loaded dividers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg  <= {NUM_CH{RESET_DIV}};
            cnt      <= '0;
            tick     <= '0;
            any_tick <= 1'b0;
        end else begin
            div_reg  <= next_div;
            cnt      <= cnt_d;
            tick     <= tick_d;
            any_tick <= |tick_d;
        end
    end

endmodule

// File: doc/clk_tick_gen.md
CLK_TICK_GEN -- requirements
Module: clk_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels, range 1..16.
REQ-002 Parameter CNT_WIDTH, default 8: divider and counter width per channel, range 2..32.
REQ-003 Parameter RESET_DIV, default 0: divider value loaded into every channel at reset, less than 2**CNT_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  NUM_CH  per-channel count enable.
REQ-007 restart  input  NUM_CH  per-channel synchronous counter restart strobe.
REQ-008 load  input  NUM_CH  per-channel divider load strobe.
REQ-009 div_in  input  NUM_CH*CNT_WIDTH  divider values; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-010 tick  output  NUM_CH  per-channel registered one-cycle tick pulse.
REQ-011 any_tick  output  1  registered OR of all channel ticks for the same cycle.

Function
REQ-012 Each channel SHALL hold a divider register div_reg[i] and a down-counter cnt[i], both CNT_WIDTH bits.
REQ-013 next_div[i] SHALL be div_in slice i when load[i]=1, otherwise div_reg[i]; on load[i]=1, div_reg[i] SHALL take div_in slice i at the edge.
REQ-014 Priority per channel, per edge: restart, then enabled count, then hold.
REQ-015 restart[i]=1: cnt[i] <= next_div[i]; tick[i] <= 0, regardless of enable[i] or cnt[i].
REQ-016 restart[i]=0, enable[i]=1, cnt[i]=0: tick[i] <= 1; cnt[i] <= next_div[i] (reload).
REQ-017 restart[i]=0, enable[i]=1, cnt[i]!=0: cnt[i] <= cnt[i]-1; tick[i] <= 0.
REQ-018 restart[i]=0, enable[i]=0: cnt[i] holds; tick[i] <= 0.
REQ-019 Period: with constant divider D and enable held high, ticks SHALL occur every D+1 cycles; D=0 gives a tick every cycle.
REQ-020 Latency: tick SHALL be asserted in the cycle after the edge that samples cnt=0 with enable=1; no combinational input-to-output path.
REQ-021 A load without restart SHALL NOT change cnt[i]; the new divider takes effect at the next reload, or immediately if the reload happens at the same edge.
REQ-022 The counter SHALL never wrap: decrement occurs only from nonzero values; a divider of 2**CNT_WIDTH-1 SHALL give a period of 2**CNT_WIDTH.
REQ-023 Channels SHALL be fully independent; activity on one channel SHALL NOT affect another channel's timing.
REQ-024 any_tick SHALL equal the OR reduction of the next tick vector, registered on the same edge as tick.

Reset
REQ-025 On rst=1, asynchronously: tick=0, any_tick=0, cnt[i]=0, div_reg[i]=RESET_DIV for all i.
REQ-026 While rst=1, all inputs SHALL be ignored.
REQ-027 At the first edge after rst deasserts, an enabled channel SHALL tick, because cnt=0.
REQ-028 Reset asserted mid-period SHALL discard counter progress and any loaded divider.

Verification
REQ-029 NUM_CH=4, CNT_WIDTH=8. Load ch0 with 3, restart ch0, then enable ch0 -> tick[0] high one cycle in every 4; any_tick mirrors it.
REQ-030 Divider 0 on ch1 with enable held -> tick[1] high every cycle; divider 255 on ch2 -> period exactly 256 cycles.
REQ-031 Ch0 running with divider 3; at cnt=1, load 5 without restart -> the current period ends at 4 cycles, then 6-cycle periods follow; load and reload at the same edge -> new period 6 immediately.
REQ-032 Enable dropped for 10 cycles mid-count, then raised again -> no ticks while low; the pending tick is delayed by exactly 10 cycles. Restart and enable with cnt=0 at the same edge -> no tick, cnt reloads.
REQ-033 rst pulsed asynchronously (not aligned to clk) during active counting -> tick and any_tick drop immediately; div_reg returns to RESET_DIV; after release, the first enabled edge yields a tick.
REQ-034 All 4 channels enabled with dividers 0, 1, 2, 3 -> independent periods of 1, 2, 3 and 4 cycles; any_tick equals the per-cycle OR of the four.
